uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Frame controller for the UART transmitter. It accepts a byte-valid strobe from upstream and sequences the adjacent serializer stage through its `ser_EN`. It builds the line frame: start bit, 8 data bits LSB-first, optional parity bit, then stop bit. It drives the serial line `TX_OUT` and a `Busy` flag back to upstream.

## Interface
- `DATA_WIDTH`, 8, data bits per frame. Sets the `P_Data` width and the DATA-state length. Only 8 is supported by the serializer stage.

- `CLK` in 1: single clock. All state changes on its rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `P_Data` in 8: parallel byte. Used only for parity, sampled at frame acceptance. The serializer loads the same byte from the same `Data_Valid`.
- `Data_Valid` in 1: one-cycle request to send `P_Data`.
- `PAR_EN` in 1: 1 = frame carries a parity bit. Sampled at acceptance.
- `PAR_TYP` in 1: 0 = even, 1 = odd. Sampled at acceptance.
- `ser_OUT` in 1: registered serial data from the serializer.
- `ser_EN` out 1: serializer shift enable.
- `TX_OUT` out 1: serial line. Idle level is 1.
- `Busy` out 1: frame in progress.

## Operation
- Registered state, 3 bits. Encoding: IDLE=000, START=001, DATA=011, PARITY=010, STOP=110.
- Output mux:
  - `TX_OUT` is a combinational mux of registered signals only.
  - IDLE→1, START→0, DATA→`ser_OUT`, PARITY→`par_bit`, STOP→1.
- `Busy` = 1 in every state except IDLE.
- `ser_EN` = 1 in START and DATA, 0 otherwise.

State transitions:
- **IDLE**:
  - `Data_Valid`=1 → START.
  - On the same edge, latch:
    - `par_bit` = `^P_Data` XOR `PAR_TYP`
    - `par_en_r` = `PAR_EN`
  - Otherwise stay in IDLE.
- **START**: unconditional → DATA; `bit_cnt` <= 0. The serializer shifts bit0 onto `ser_OUT` during this cycle.
- **DATA**:
  - `bit_cnt` increments each cycle.
  - At `bit_cnt`=7: go to PARITY if `par_en_r`, else STOP.
- **PARITY**: unconditional → STOP.
- **STOP**: unconditional → IDLE.

Other rules:
- `Data_Valid` in any state other than IDLE is ignored: no latch, no state change. Upstream must not assert `Data_Valid` while `Busy`=1.
- `bit_cnt` is 3 bits. It holds its value outside DATA and never wraps within a frame.
- Simultaneous `Data_Valid` and reset release: reset dominates while `RST`=0. The first accepted strobe is the one on the first edge with `RST`=1.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, `bit_cnt`=0, `par_bit`=0, `par_en_r`=0
  - hence `TX_OUT`=1, `Busy`=0, `ser_EN`=0 immediately
- Reset mid-frame aborts the frame. The line returns to 1 without a stop-bit cycle.
- `Data_Valid` sampled at edge k gives:
  - cycle k+1: START, `TX_OUT`=0, `Busy`=1, `ser_EN`=1
  - cycles k+2..k+9: DATA, `TX_OUT`=bit0..bit7, `ser_EN`=1
  - cycle k+10: PARITY if enabled, otherwise STOP
  - cycle k+11: STOP if parity enabled
  - then IDLE, `Busy`=0
- Frame length on the line is 10 cycles without parity and 11 with parity.
- Minimum spacing between accepted strobes is 11 (no parity) or 12 (parity) cycles, because IDLE is always visited for at least one cycle.
- `ser_EN` is high for exactly 9 consecutive cycles per frame.
- `TX_OUT` changes only in the cycle after a `CLK` edge, or asynchronously on reset assertion.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: behaviour as above.
- Undefined:
  - `par_bit`, `par_en_r` and the PARITY state are not built.
  - DATA always exits to STOP, and every frame is 10 cycles.
  - `PAR_EN`/`PAR_TYP` ports remain present but unused.

## Test plan
- **Reset check:** hold `RST`=0 for 3 cycles, then release with no `Data_Valid` → `TX_OUT`=1, `Busy`=0, `ser_EN`=0 for 20 cycles.
- **0xA5, no parity:** `P_Data`=0xA5, `PAR_EN`=0, one-cycle `Data_Valid` → `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 over k+1..k+10. `Busy` high for 10 cycles and `ser_EN` high for 9.
- **0xA5, even parity:** `PAR_EN`=1, `PAR_TYP`=0 → parity cycle k+10 gives `TX_OUT`=0, stop at k+11, `Busy` high for 11 cycles. Repeat with `PAR_TYP`=1 → parity bit = 1.
- **0x01, even parity:** → parity bit = 1. **0x00, odd parity:** → parity bit = 1.
- **Ignored strobe:** a second `Data_Valid` at k+5 with `PAR_EN`/`PAR_TYP` changed → ignored. The frame and parity of the first byte are unchanged, and no extra frame follows.
- **Reset mid-frame:** pulse `RST` low at k+6 → `TX_OUT`=1, `Busy`=0, `ser_EN`=0 without waiting for an edge. A new `Data_Valid` after release yields a full, correct frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// Parity bit and PARITY state are built only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_Data,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  ser_OUT,
   output logic                  ser_EN,
   output logic                  TX_OUT,
   output logic                  Busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      START  = 3'b001,
      DATA   = 3'b011,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'b010,
`endif
      STOP   = 3'b110
   } state_e;

   localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       busy_q, busy_d;
   logic       ser_en_q, ser_en_d;

`ifdef UART_TX_PARITY_EN
   logic       par_bit_q, par_bit_d;
   logic       par_en_q, par_en_d;
`else
   logic       unused_par_inputs;
   assign unused_par_inputs = ^{P_Data, PAR_EN, PAR_TYP};
`endif

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
      par_bit_d = par_bit_q;
      par_en_d  = par_en_q;
`endif
      case (state_q)
         IDLE: begin
            if (Data_Valid) begin
               state_d   = START;
`ifdef UART_TX_PARITY_EN
               par_bit_d = (^P_Data) ^ PAR_TYP;
               par_en_d  = PAR_EN;
`endif
            end
         end
         START: begin
            state_d   = DATA;
            bit_cnt_d = '0;
         end
         DATA: begin
            // counter parks on the last index so it never wraps inside a frame
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
               state_d = par_en_q ? PARITY : STOP;
`else
               state_d = STOP;
`endif
            end else begin
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: state_d = STOP;
`endif
         STOP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // status flags are registered from the next-state decode
      busy_d   = (state_d != IDLE);
      ser_en_d = (state_d == START) || (state_d == DATA);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         busy_q    <= 1'b0;
         ser_en_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit_q <= 1'b0;
         par_en_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         busy_q    <= busy_d;
         ser_en_q  <= ser_en_d;
`ifdef UART_TX_PARITY_EN
         par_bit_q <= par_bit_d;
         par_en_q  <= par_en_d;
`endif
      end
   end

   always_comb begin
      TX_OUT = 1'b1;
      case (state_q)
         START:   TX_OUT = 1'b0;
         DATA:    TX_OUT = ser_OUT;
`ifdef UART_TX_PARITY_EN
         PARITY:  TX_OUT = par_bit_q;
`endif
         default: TX_OUT = 1'b1;
      endcase
   end

   assign Busy   = busy_q;
   assign ser_EN = ser_en_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: queue-based frame model plus literal frame checks.
// Parity expectations follow UART_TX_PARITY_EN in the same way as the design build.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_BUILT = 1'b1;
`else
   localparam bit PAR_BUILT = 1'b0;
`endif

   localparam logic [2:0] IDLE_EXP = 3'b100;  // {TX_OUT, Busy, ser_EN}

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] P_Data = '0;
   logic       Data_Valid = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       ser_OUT = 1'b1;
   logic       ser_EN;
   logic       TX_OUT;
   logic       Busy;

   int compared = 0;
   int mismatched = 0;
   bit chk_en = 1'b0;

   uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .P_Data    (P_Data),
      .Data_Valid(Data_Valid),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .ser_OUT   (ser_OUT),
      .ser_EN    (ser_EN),
      .TX_OUT    (TX_OUT),
      .Busy      (Busy)
   );

   always #5 CLK = ~CLK;

   // reference model: a queue of per-cycle expected outputs for the frame in flight
   logic [2:0] exp_q[$];
   logic [2:0] cur = IDLE_EXP;
   bit         cur_idle = 1'b1;
   logic [7:0] sreg = '0;

   task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt);
      exp_q.push_back(3'b011);
      for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1, 1'b1});
      if (PAR_BUILT && pe) exp_q.push_back({(^d) ^ pt, 1'b1, 1'b0});
      exp_q.push_back(3'b110);
   endtask

   // also acts as the serializer stage: loads on acceptance, shifts while ser_EN
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         exp_q.delete();
         cur      = IDLE_EXP;
         cur_idle = 1'b1;
         sreg     = '0;
         ser_OUT <= 1'b1;
      end else begin
         if (ser_EN) begin
            ser_OUT <= sreg[0];
            sreg     = sreg >> 1;
         end
         if (cur_idle && Data_Valid) begin
            build_frame(P_Data, PAR_EN, PAR_TYP);
            sreg = P_Data;
         end
         if (exp_q.size() > 0) begin
            cur      = exp_q.pop_front();
            cur_idle = 1'b0;
         end else begin
            cur      = IDLE_EXP;
            cur_idle = 1'b1;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         compared++;
         if ({TX_OUT, Busy, ser_EN} !== cur) begin
            mismatched++;
            $display("FAIL cycle_model t=%0t {TX_OUT,Busy,ser_EN} actual=%b required=%b",
                     $time, {TX_OUT, Busy, ser_EN}, cur);
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   task automatic capture(input logic [7:0] d, input logic pe, input logic pt,
                          input int extra_at, output logic [11:0] seq,
                          output int busy_n, output int sen_n);
      seq    = '0;
      busy_n = 0;
      sen_n  = 0;
      @(posedge CLK); #2;
      P_Data = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
      @(posedge CLK); #2;
      Data_Valid = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge CLK);
         seq    = {seq[10:0], TX_OUT};
         busy_n += int'(Busy);
         sen_n  += int'(ser_EN);
         if (extra_at != 0 && i == extra_at) begin
            Data_Valid = 1'b1;
            P_Data     = 8'($urandom);
            PAR_EN     = ~pe;
            PAR_TYP    = ~pt;
         end else if (extra_at != 0 && i == extra_at + 1) begin
            Data_Valid = 1'b0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] seq;
      int          bn, sn;
      int          cnt_busy, cnt_sen, cnt_low;
      logic [7:0]  d;
      logic        pe, pt;
      int          extra;

      #1 RST = 1'b0;
      #1;
      chk("reset_async_outputs", {TX_OUT, Busy, ser_EN}, IDLE_EXP);
      chk_en = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK) RST = 1'b1;

      cnt_busy = 0; cnt_sen = 0; cnt_low = 0;
      repeat (20) begin
         @(negedge CLK);
         cnt_busy += int'(Busy);
         cnt_sen  += int'(ser_EN);
         cnt_low  += int'(!TX_OUT);
      end
      chk("idle_busy_cycles", cnt_busy, 0);
      chk("idle_ser_en_cycles", cnt_sen, 0);
      chk("idle_tx_low_cycles", cnt_low, 0);

      capture(8'hA5, 1'b0, 1'b0, 0, seq, bn, sn);
      chk("a5_nopar_line", seq, 12'b010100101111);
      chk("a5_nopar_busy", bn, 10);
      chk("a5_nopar_ser_en", sn, 9);

      capture(8'hA5, 1'b1, 1'b0, 0, seq, bn, sn);
      chk("a5_even_line", seq, PAR_BUILT ? 12'b010100101011 : 12'b010100101111);
      chk("a5_even_busy", bn, PAR_BUILT ? 11 : 10);
      chk("a5_even_ser_en", sn, 9);

      capture(8'hA5, 1'b1, 1'b1, 0, seq, bn, sn);
      chk("a5_odd_line", seq, 12'b010100101111);
      chk("a5_odd_busy", bn, PAR_BUILT ? 11 : 10);

      capture(8'h01, 1'b1, 1'b0, 0, seq, bn, sn);
      chk("01_even_line", seq, 12'b010000000111);
      chk("01_even_busy", bn, PAR_BUILT ? 11 : 10);

      capture(8'h00, 1'b1, 1'b1, 0, seq, bn, sn);
      chk("00_odd_line", seq, 12'b000000000111);
      chk("00_odd_busy", bn, PAR_BUILT ? 11 : 10);

      capture(8'hA5, 1'b1, 1'b0, 5, seq, bn, sn);
      chk("ignored_strobe_line", seq, PAR_BUILT ? 12'b010100101011 : 12'b010100101111);
      chk("ignored_strobe_busy", bn, PAR_BUILT ? 11 : 10);
      cnt_busy = 0;
      repeat (15) begin
         @(negedge CLK);
         cnt_busy += int'(Busy);
      end
      chk("ignored_strobe_no_extra_frame", cnt_busy, 0);

      @(posedge CLK); #2;
      P_Data = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      @(posedge CLK); #2;
      Data_Valid = 1'b0;
      repeat (6) @(negedge CLK);
      #1 RST = 1'b0;
      #1;
      chk("midframe_reset_async", {TX_OUT, Busy, ser_EN}, IDLE_EXP);
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK) RST = 1'b1;
      capture(8'h3C, 1'b0, 1'b0, 0, seq, bn, sn);
      chk("after_reset_line", seq, 12'b000111100111);
      chk("after_reset_busy", bn, 10);
      chk("after_reset_ser_en", sn, 9);

      for (int n = 0; n < 40; n++) begin
         d     = 8'($urandom);
         pe    = 1'($urandom_range(0, 1));
         pt    = 1'($urandom_range(0, 1));
         extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
         capture(d, pe, pt, extra, seq, bn, sn);
         chk("rand_busy_len", bn, (PAR_BUILT && pe) ? 11 : 10);
         chk("rand_ser_en_len", sn, 9);
         repeat ($urandom_range(0, 3)) @(posedge CLK);
      end

      repeat (3) @(negedge CLK);
      chk("model_queue_drained", exp_q.size(), 0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
